// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory responder and the decoder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  // Index/counter width for n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; q only updates on a read strobe and is cleared by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: fixed-latency LW/SW service with pipeline stall.
// Optional range checking of the word index is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int IW = idx_w(DEPTH);
  localparam int CW = idx_w(LATENCY);

  dmem_state_t   state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q, sup_q, err_q;

  logic req, both, misal, oob, bad, commit;

  assign req   = MemRead_i | MemWrite_i;
  assign both  = MemRead_i & MemWrite_i;
  assign misal = |addr_i[1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  assign oob = (addr_i[31:2] >= DEPTH_W);
`else
  // Upper address bits are deliberately dropped: the index wraps modulo DEPTH.
  logic unused_hi;
  assign unused_hi = &{1'b0, addr_i[31:IW+2]};
  assign oob = 1'b0;
`endif

  assign bad = misal | oob;

  // Stall rises combinationally on a request seen in IDLE so the pipeline freezes that cycle.
  assign stall_o = (state == BUSY) || (state == IDLE && req);

  // Gated by reset so an abandoned access can never commit on the reset edge.
  assign commit = (state == BUSY) && (cnt == '0) && !sup_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          state   <= BUSY;
          cnt     <= CW'(LATENCY - 1);
          idx_q   <= addr_i[IW+1:2];
          wdata_q <= wdata_i;
          wr_q    <= MemWrite_i;
          sup_q   <= bad;
          err_q   <= bad | both;
        end
        BUSY: if (cnt == '0) begin
          state  <= RESP;
          done_o <= 1'b1;
          err_o  <= err_q;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (commit & wr_q),
    .re    (commit & ~wr_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .q     (rdata_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, LATENCY=2).
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        stall_o, done_o, err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one access starting in the current cycle (just after a rising edge),
  // checks the stall window and the completion pulse, and returns one cycle after RESP.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_err,
                        input logic chk_rd, input logic [31:0] exp_rd);
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = wd;
    for (int c = 0; c <= LATENCY; c++) begin
      @(negedge clk_i);
      chk($sformatf("stall_c%0d@%h", c, a), {31'd0, stall_o}, 32'd1);
      chk($sformatf("done_c%0d@%h", c, a), {31'd0, done_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk($sformatf("resp_done@%h", a), {31'd0, done_o}, 32'd1);
    chk($sformatf("resp_err@%h", a), {31'd0, err_o}, {31'd0, exp_err});
    chk($sformatf("resp_stall@%h", a), {31'd0, stall_o}, 32'd0);
    if (chk_rd) chk($sformatf("rdata@%h", a), rdata_o, exp_rd);
    // Requests were held through RESP (ignored there); drop them before the edge.
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic e);
    access(1'b0, 1'b1, a, d, e, 1'b0, 32'd0);
  endtask

  task automatic lw(input logic [31:0] a, input logic e, input logic [31:0] exp_rd);
    access(1'b1, 1'b0, a, 32'd0, e, 1'b1, exp_rd);
  endtask

  initial begin
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_done",  {31'd0, done_o},  32'd0);
    chk("rst_err",   {31'd0, err_o},   32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("idle_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;

    // Write then read back; successive calls are back-to-back after each done pulse.
    sw(32'h10, 32'hDEADBEEF, 1'b0);
    lw(32'h10, 1'b0, 32'hDEADBEEF);

    // Misaligned read leaves rdata untouched; misaligned write is dropped.
    sw(32'h14, 32'h12345678, 1'b0);
    lw(32'h14, 1'b0, 32'h12345678);
    lw(32'h13, 1'b1, 32'h12345678);
    sw(32'h12, 32'h00000777, 1'b1);
    lw(32'h10, 1'b0, 32'hDEADBEEF);

    // Both request lines: write wins, error flagged.
    access(1'b1, 1'b1, 32'h20, 32'h000000AA, 1'b1, 1'b1, 32'hDEADBEEF);
    lw(32'h20, 1'b0, 32'h000000AA);

    // Reset while BUSY abandons the pending store.
    sw(32'h40, 32'h11111111, 1'b0);
    MemWrite_i = 1'b1; addr_i = 32'h40; wdata_i = 32'h55;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_busy_stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0; MemWrite_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_done",  {31'd0, done_o},  32'd0);
    chk("midrst_rdata", rdata_o, 32'd0);
    @(posedge clk_i); #1;
    lw(32'h40, 1'b0, 32'h11111111);

    // Out-of-range index: wraps onto word 0 unless bounds checking is built in.
    sw(32'h0, 32'hCAFEF00D, 1'b0);
    lw(32'h0, 1'b0, 32'hCAFEF00D);
`ifdef DMEM_BOUNDS_CHECK_EN
    sw(32'h1000, 32'h00000099, 1'b1);
    lw(32'h0, 1'b0, 32'hCAFEF00D);
`else
    sw(32'h1000, 32'h00000099, 1'b0);
    lw(32'h0, 1'b0, 32'h00000099);
`endif

    @(negedge clk_i);
    chk("final_idle_stall", {31'd0, stall_o}, 32'd0);
    chk("final_idle_done",  {31'd0, done_o},  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RV32 core's MEM stage.
- The decoder issues MemRead/MemWrite for LW/SW; this block services those requests against a word-addressed on-chip array with fixed multi-cycle latency.
- Asserts stall_o back to the hazard logic until the access completes.
- Sits between the EX/MEM pipeline register and the MEM/WB register.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- LATENCY, 2, BUSY cycles per access (minimum 1).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- MemRead_i  in  1  read request, held stable by the pipeline while stall_o=1
- MemWrite_i  in  1  write request, held stable while stall_o=1
- addr_i  in  32  byte address (ALU result)
- wdata_i  in  32  store data
- rdata_o  out  32  load data, registered
- stall_o  out  1  pipeline freeze request
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse, coincident with done_o

Behaviour:
- Reset (sync, active-high): state=IDLE, counter=0, rdata_o=0, done_o=0, err_o=0. stall_o=0 because it is decoded from IDLE with no request. Array contents are not cleared.
- Reset mid-access: the access is abandoned and a pending write is never committed.
- State machine: IDLE, BUSY, RESP.
- IDLE:
  - No request: stall_o=0.
  - On MemRead_i|MemWrite_i: stall_o=1 combinationally in the same cycle. Capture addr, wdata and op. Load counter with LATENCY-1. Go to BUSY.
  - Both request lines high: treated as a write (write priority) and err_o is flagged at completion.
- BUSY:
  - stall_o=1.
  - Counter decrements each cycle; when counter==0, go to RESP.
  - On that edge: a write commits to array[addr[31:2] mod DEPTH], or a read loads rdata_o.
- RESP:
  - stall_o=0, done_o=1, err_o per error conditions.
  - Request inputs are ignored this cycle, because the pipeline advances at the end of it.
  - Next state: IDLE.
- Timing: a request first seen in cycle 0 gives stall_o high for cycles 0..LATENCY and done_o in cycle LATENCY+1. Total stall is LATENCY+1 cycles.
- Misalignment: addr[1:0]!=0 suppresses the access (no write, rdata_o unchanged). The FSM still completes with full latency and err_o=1.
- rdata_o holds its value until the next successful read completes. Writes and errored reads do not change it.
- A read of a just-written address returns the new data, since accesses are strictly serialized.
- Requests are never queued; at most one access is outstanding.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN.
- Defined: word index addr[31:2] >= DEPTH suppresses the access and raises err_o at completion, same as misalignment.
- Undefined: the index wraps modulo DEPTH, the access proceeds, and no error is raised for range.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
  - the word-index width derivation for DEPTH
  - opcode constants for LW (7'b0000011) and SW (7'b0100011), shared with the decoder
- Natural sub-module dmem_array: single-port synchronous RAM with write enable and a registered read.
  - FSM, counter and error logic stay in dmem_responder.

Test Plan:
- Write then read: SW wdata=32'hDEADBEEF at addr 0x10, then LW addr 0x10.
  - Each access has stall_o high for 3 cycles, then a done_o pulse.
  - The read ends with rdata_o=32'hDEADBEEF and err_o=0.
- Misaligned: LW addr 0x13 while rdata_o=32'h12345678.
  - done_o and err_o pulse together in cycle 3; rdata_o stays 32'h12345678.
  - A subsequent read of 0x10 still returns 32'hDEADBEEF.
- Simultaneous read and write: MemRead_i=MemWrite_i=1, addr 0x20, wdata 32'h0000_00AA.
  - Write commits and err_o=1.
  - A subsequent LW 0x20 returns 32'h000000AA.
- Reset mid-access: SW 32'h55 to 0x40 with rst_i asserted in cycle 1 (BUSY).
  - Next cycle: IDLE, stall_o=0, done_o=0, rdata_o=0.
  - A subsequent LW 0x40 returns the prior contents, not 32'h55.
- Range, DEPTH=1024, SW to addr 0x1000 (index 1024):
  - With DMEM_BOUNDS_CHECK_EN: err_o=1 and word 0 is unchanged.
  - Without it: word 0 is overwritten and err_o=0.
- Back-to-back: LW presented in the cycle immediately after a done_o pulse.
  - It is accepted in IDLE, stall_o rises the same cycle, and no request is lost.
